// File: rtl/collision_probe.sv
// Collision probe scanner: on start, reads ten tile-map points around the character's
// bounding box and publishes up/down/left/right blocked flags together with a done pulse.
module collision_probe #(
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int MAP_ROWS = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x_position,
  input  logic [7:0]  y_position,
  input  logic [10:0] scroll_x,
  output logic [11:0] tile_addr,
  input  logic        tile_solid,
  output logic        left_blocked,
  output logic        right_blocked,
  output logic        up_blocked,
  output logic        down_blocked,
  output logic        busy,
  output logic        done,
  output logic [1:0]  scan_state
);

  // Handshake: start is sampled only in IDLE; busy covers the scan through the done
  // cycle; done is a single-cycle pulse in the cycle the four flags change together.

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic signed [8:0] Y_MAX = 9'(MAP_ROWS * 8 - 1);

  state_t             state;
  logic [3:0]         idx;
  logic [10:0]        x0;
  logic signed [8:0]  y0;
  logic [9:0]         shadow;

  logic [10:0]        x_start;
  logic signed [8:0]  y_start;

  assign x_start    = scroll_x + {3'b000, x_position};
  assign y_start    = signed'({1'b0, y_position});
  assign scan_state = state;

  function automatic logic [10:0] probe_dx(input logic [3:0] i);
    case (i)
      4'd1, 4'd3:       probe_dx = 11'(CHAR_W - 1);
      4'd4, 4'd5, 4'd6: probe_dx = 11'h7ff;
      4'd7, 4'd8, 4'd9: probe_dx = 11'(CHAR_W);
      default:          probe_dx = 11'd0;
    endcase
  endfunction

  function automatic logic signed [8:0] probe_dy(input logic [3:0] i);
    case (i)
      4'd0, 4'd1: probe_dy = -9'sd1;
      4'd2, 4'd3: probe_dy = 9'(CHAR_H);
      4'd5, 4'd8: probe_dy = 9'(CHAR_H / 2);
      4'd6, 4'd9: probe_dy = 9'(CHAR_H - 1);
      default:    probe_dy = 9'sd0;
    endcase
  endfunction

  // Rows above the screen or below the last map row read as open.
  function automatic logic probe_oor(input logic signed [8:0] y, input logic [3:0] i);
    logic signed [8:0] py;
    py = y + probe_dy(i);
    probe_oor = (py < 9'sd0) || (py > Y_MAX);
  endfunction

  function automatic logic [11:0] probe_addr(input logic [10:0] x, input logic signed [8:0] y,
                                             input logic [3:0] i);
    logic [10:0]       px;
    logic signed [8:0] py;
    logic [3:0]        row;
    px  = x + probe_dx(i);
    py  = y + probe_dy(i);
    row = probe_oor(y, i) ? 4'd0 : py[6:3];
    probe_addr = {row, px[10:3]};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= 4'd0;
      x0            <= 11'd0;
      y0            <= 9'sd0;
      shadow        <= 10'd0;
      tile_addr     <= 12'd0;
      left_blocked  <= 1'b0;
      right_blocked <= 1'b0;
      up_blocked    <= 1'b0;
      down_blocked  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            x0        <= x_start;
            y0        <= y_start;
            idx       <= 4'd0;
            tile_addr <= probe_addr(x_start, y_start, 4'd0);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Read data lags the address by one cycle; results shift in with probe 0 ending at bit 0.
          if (idx != 4'd0)
            shadow <= {tile_solid & ~probe_oor(y0, idx - 4'd1), shadow[9:1]};
          if (idx == 4'd9) begin
            state <= DRAIN;
          end else begin
            idx       <= idx + 4'd1;
            tile_addr <= probe_addr(x0, y0, idx + 4'd1);
          end
        end
        DRAIN: begin
          shadow <= {tile_solid & ~probe_oor(y0, 4'd9), shadow[9:1]};
          state  <= DONE;
        end
        DONE: begin
          up_blocked    <= shadow[0] | shadow[1];
          down_blocked  <= shadow[2] | shadow[3];
          left_blocked  <= |shadow[6:4];
          right_blocked <= |shadow[9:7];
          done          <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/collision_probe.md
# collision_probe

Scan engine that produces the `left_blocked`, `right_blocked`, `up_blocked` and `down_blocked` flags consumed by the character movement block. On each `start` pulse it latches the character's screen position and the level scroll offset, then reads ten probe points around the character's bounding box from the level tile map through a synchronous one-cycle-latency read port. It publishes all four flags together with a one-cycle `done` pulse. It sits between the character movement block and the level tile-map RAM, and is triggered once per frame.

## Interface
- `CHAR_W`, default 8: character width in pixels; the probe offsets below are fixed for this value.
- `CHAR_H`, default 16: character height in pixels; the probe offsets below are fixed for this value.
- `MAP_ROWS`, default 15: tile rows on screen (120 px); valid probe y range is 0..119.
- `clock` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a scan; sampled only in IDLE.
- `x_position` in 8: character left edge, screen pixels.
- `y_position` in 8: character top edge, screen pixels; values ≥120 mean the head is off-screen.
- `scroll_x` in 11: world x of screen column 0.
- `tile_addr` out 12: tile-map read address {row[3:0], col[7:0]}.
- `tile_solid` in 1: solid bit of the tile at the previous cycle's `tile_addr`.
- `left_blocked`, `right_blocked`, `up_blocked`, `down_blocked` out 1 each: registered flags, held between scans.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse in the cycle the flags update.

## Operation
- **Latching:** on accepted `start`, latch x0 = (scroll_x + x_position) mod 2048 (11-bit) and y0 = y_position zero-extended to 9-bit signed.
- **Probe sequence** (index: px, py):
  - 0: x0, y0−1
  - 1: x0+7, y0−1
  - 2: x0, y0+16
  - 3: x0+7, y0+16
  - 4: x0−1, y0
  - 5: x0−1, y0+8
  - 6: x0−1, y0+15
  - 7: x0+8, y0
  - 8: x0+8, y0+8
  - 9: x0+8, y0+15
- **Probe arithmetic:**
  - px is computed mod 2048; tile column = px[10:3].
  - py is computed in 9-bit signed; tile row = py[6:3].
- **Out-of-range rows:** a probe with py < 0 or py > 119 is out of range. It still issues a read (`tile_addr` row forced to 0), but its result is forced to 0 (open).
- **Flag mapping:**
  - up = p0|p1
  - down = p2|p3
  - left = p4|p5|p6
  - right = p7|p8|p9
- **Result accumulation:** results accumulate in internal shadow bits. The four outputs load simultaneously only at `done`, so the movement block never sees a partial scan.
- **FSM:**
  - IDLE: on `start` go to ISSUE with probe index 0.
  - ISSUE: drive the address for probe i each cycle. Capture `tile_solid` for probe i−1. After i=9, go to DRAIN.
  - DRAIN: capture probe 9, then go to DONE.
  - DONE: load the flags, pulse `done`, return to IDLE.
- **Start handling:** `start` while `busy` is ignored and is not queued. `start` held high re-triggers a new scan on the first IDLE cycle after DONE.
- **Reset**, including mid-scan, takes effect at the next edge:
  - state goes to IDLE;
  - all flags, shadow bits, `busy` and `done` go to 0;
  - `tile_addr` goes to 0.
- **Flags after reset:** all flags are 0 after reset, so the character falls until the first scan completes.

## Timing
- `start` sampled high in IDLE at edge T0.
- `tile_addr` carries probe 0 during cycle T1 and probe i during cycle T1+i; probe 9 is at T10.
- `tile_solid` for probe i is valid during cycle T2+i.
- `done` is high and the flags hold new values from edge T12. Fixed scan latency is 12 cycles.
- `busy` is high from T1 through T12 inclusive.
- The earliest next accepted `start` is at edge T13, giving 13 cycles per scan back-to-back.
- No dependency on `x_position`, `y_position` or `scroll_x` after T0.

## Test plan
- **Reset values:** assert `reset` 2 cycles mid-scan (at T5). Required: all flags 0, `busy` 0, `done` 0, `tile_addr` 0. A scan started afterwards completes normally in 12 cycles.
- **Floor:** solid floor at row 10 only; x_position=72, y_position=64, scroll_x=0. `start` → `done` at T12 with down=1 and up, left, right = 0. Probe 2 `tile_addr` = {4'd10, 8'd9}.
- **Right wall:** solid column 10 at rows 8–9; y_position=64, x_position=72. Required: right=1 (px=80) and left=0.
- **Off-screen head:** y_position=0 with solid row 0. Required: up=0, since py=−1 is forced open. With y_position=110, down=0, since py=126 is out of range.
- **Scroll wrap:** scroll_x=2044, x_position=0, solid tile at column 0 only. Required: probe 1 px=3 maps to col 0 and the right probes px=4 map to col 0, so right=1. Left probe px=2043 maps to col 255, so left=0.
- **Start while busy:** pulse `start` at T0 and T5 with different positions. Required: exactly one `done` at T12, the flags reflect the T0 position, and no second scan occurs.
